// File: rtl/alu_hazard_ctrl_pkg.sv
// alu_hazard_ctrl_pkg: ALU mux select encodings, bus widths and forwarding helper shared by the hazard controller
package alu_hazard_ctrl_pkg;
   localparam int ALU_SEL_W = 2;
   localparam int REG_ADDR_BUS_W = 5;
   typedef enum logic [ALU_SEL_W-1:0] {
      FROM_REG     = 2'b00,
      FROM_ALU_MEM = 2'b01,
      FROM_MEM_WB  = 2'b10
   } alu_mux_select_bus_t;
   function automatic alu_mux_select_bus_t fwd_sel(input logic mem_hit, input logic wb_hit);
      return mem_hit ? FROM_ALU_MEM : wb_hit ? FROM_MEM_WB : FROM_REG;
   endfunction
endpackage

// File: rtl/alu_hazard_ctrl_fwd_select_unit.sv
// fwd_select_unit: forwarding source for one ALU operand (rs, use_rs, ALU_MEM/MEM_WB record fields in; sel out)
module fwd_select_unit import alu_hazard_ctrl_pkg::*; #(
   parameter int REG_ADDR_W = REG_ADDR_BUS_W
) (
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic                  use_rs,
   input  logic                  mem_valid,
   input  logic                  mem_reg_write,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  wb_valid,
   input  logic                  wb_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   output alu_mux_select_bus_t   sel
);
   logic mem_hit, wb_hit;
   assign mem_hit = use_rs & mem_valid & mem_reg_write & (mem_rd != '0) & (mem_rd == rs);
   assign wb_hit = use_rs & wb_valid & wb_reg_write & (wb_rd != '0) & (wb_rd == rs);
   assign sel = fwd_sel(mem_hit, wb_hit);
endmodule

// File: rtl/alu_hazard_ctrl.sv
// alu_hazard_ctrl: execute-stage forwarding selects, load-use stall/bubble and flush handling
// in : clk, rst, decValid, decRs1, decRs2, decUsesRs2, decRd, decRegWrite, decMemRead, flush
// out: select1, select2, stall, bubble; stallCount, flushCount when ALU_HAZARD_PERF_EN is defined
module alu_hazard_ctrl import alu_hazard_ctrl_pkg::*; #(
   parameter int REG_ADDR_W = REG_ADDR_BUS_W,
   parameter int SEL_W = ALU_SEL_W
`ifdef ALU_HAZARD_PERF_EN
   ,
   parameter int PERF_CNT_W = 32
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  decValid,
   input  logic [REG_ADDR_W-1:0] decRs1,
   input  logic [REG_ADDR_W-1:0] decRs2,
   input  logic                  decUsesRs2,
   input  logic [REG_ADDR_W-1:0] decRd,
   input  logic                  decRegWrite,
   input  logic                  decMemRead,
   input  logic                  flush,
   output logic [SEL_W-1:0]      select1,
   output logic [SEL_W-1:0]      select2,
   output logic                  stall,
   output logic                  bubble
`ifdef ALU_HAZARD_PERF_EN
   ,
   output logic [PERF_CNT_W-1:0] stallCount,
   output logic [PERF_CNT_W-1:0] flushCount
`endif
);
   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic                  uses_rs2;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  mem_read;
   } stage_rec_t;
   stage_rec_t ex, mem, wb, dec;
   alu_mux_select_bus_t sel1, sel2;
   logic load_use, unused_fields;
   assign load_use = ex.valid & ex.mem_read & (ex.rd != '0) & decValid &
                     ((ex.rd == decRs1) | (decUsesRs2 & (ex.rd == decRs2)));
   assign stall = load_use & ~flush;
   assign bubble = load_use | flush;
   assign dec = '{valid: decValid & ~stall & ~flush, rs1: decRs1, rs2: decRs2, uses_rs2: decUsesRs2,
                  rd: decRd, reg_write: decRegWrite, mem_read: decMemRead};
   assign unused_fields = ^{wb.rs1, wb.rs2, wb.uses_rs2, wb.mem_read};
   always_ff @(posedge clk)
      if (rst) begin
         ex <= '0;
         mem <= '0;
         wb <= '0;
      end else begin
         ex <= dec;
         mem <= ex;
         wb <= mem;
      end
   fwd_select_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd1 (
      .rs(ex.rs1), .use_rs(ex.valid),
      .mem_valid(mem.valid), .mem_reg_write(mem.reg_write), .mem_rd(mem.rd),
      .wb_valid(wb.valid), .wb_reg_write(wb.reg_write), .wb_rd(wb.rd),
      .sel(sel1)
   );
   fwd_select_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd2 (
      .rs(ex.rs2), .use_rs(ex.valid & ex.uses_rs2),
      .mem_valid(mem.valid), .mem_reg_write(mem.reg_write), .mem_rd(mem.rd),
      .wb_valid(wb.valid), .wb_reg_write(wb.reg_write), .wb_rd(wb.rd),
      .sel(sel2)
   );
   assign select1 = SEL_W'(sel1);
   assign select2 = SEL_W'(sel2);
   // A load in ALU_MEM only has its address; the load-use stall must keep consumers from selecting it.
   assert property (@(posedge clk) disable iff (rst)
      !(mem.valid && mem.mem_read && (sel1 == FROM_ALU_MEM || sel2 == FROM_ALU_MEM)));
`ifdef ALU_HAZARD_PERF_EN
   always_ff @(posedge clk)
      if (rst) begin
         stallCount <= '0;
         flushCount <= '0;
      end else begin
         stallCount <= stallCount + PERF_CNT_W'(stall & ~&stallCount);
         flushCount <= flushCount + PERF_CNT_W'(flush & ~&flushCount);
      end
`endif
endmodule

// File: doc/alu_hazard_ctrl.md
Name: alu_hazard_ctrl

Overview:
- Pipeline hazard controller for the execute-stage ALU and its two 3:1 operand muxes.
- Tracks the destination of every in-flight instruction in three stages (DEC_ALU, ALU_MEM, MEM_WB).
- Generates the operand forwarding selects, detects load-use hazards and inserts one-cycle bubbles.
- Handles flush on redirect.
- Sits beside the decode stage; drives the ALU mux selects and the fetch/decode stall lines.

Parameters:
- REG_ADDR_W, 5, register index width.
- SEL_W, 2, width of each ALU mux select.
- PERF_CNT_W, 32, stall counter width (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- decValid  in  1  decode stage holds a real instruction.
- decRs1  in  REG_ADDR_W  source register 1 of the decoding instruction.
- decRs2  in  REG_ADDR_W  source register 2 of the decoding instruction.
- decUsesRs2  in  1  instruction reads rs2 (0 for imm-form ops).
- decRd  in  REG_ADDR_W  destination register.
- decRegWrite  in  1  instruction writes rd.
- decMemRead  in  1  instruction is a load.
- flush  in  1  redirect; kill the decoding instruction.
- select1  out  SEL_W  ALU operand-1 mux select.
- select2  out  SEL_W  ALU operand-2 mux select.
- stall  out  1  hold PC and decode register this cycle.
- bubble  out  1  DEC_ALU receives a NOP next edge.

Behaviour:
- Internal stage records ex, mem, wb. Each record holds {valid, rs1, rs2, usesRs2, rd, regWrite, memRead}.
- Reset: all records invalid; select1/select2 = 2'b00 (FromReg); stall = 0; bubble = 0.
- Select encoding: 00 FromReg, 01 FromALU_MEM, 10 FromMEM_WB; 11 never driven.
- Selects are combinational from registered state only (zero latency, no input-to-output path).
  - select1 = 01 if mem.valid & mem.regWrite & mem.rd != 0 & mem.rd == ex.rs1.
  - Otherwise select1 = 10 under the same test against wb.
  - Otherwise select1 = 00.
  - select2 uses the same rule on ex.rs2, gated by ex.usesRs2; forced to 00 when usesRs2 = 0.
  - ALU_MEM has priority over MEM_WB when both match.
  - x0 (rd == 0) is never forwarded.
  - An invalid ex record gives 00/00.
- Load-use hazard, loadUse = ex.valid & ex.memRead & ex.rd != 0 & decValid & (ex.rd == decRs1 | (decUsesRs2 & ex.rd == decRs2)).
  - stall = loadUse & !flush.
  - bubble = loadUse | flush.
- Advance every cycle (no global enable):
  - wb <= mem; mem <= ex.
  - ex <= decoded fields when decValid & !stall & !flush; otherwise ex <= invalid (bubble).
- Each load-use stall lasts exactly one cycle. Next cycle the load sits in mem, which is illegal for forwarding (address, not data), so the consumer waits. Data comes via MEM_WB the cycle after, through the select logic.
  - Consequence: a consumer needing a load result is held one cycle, then selects 10.
- A mem record with memRead never drives select 01; the stall guarantees this case cannot arise, and it must be assertion-checked.
- flush + loadUse in the same cycle: flush wins. stall = 0, bubble = 1, ex invalid.
- Older instructions in mem/wb continue on flush (flush only kills decode).
- Back-to-back load-use pairs each get exactly one bubble; no deadlock possible.
- rst asserted mid-stream: all records invalid on that edge regardless of stall/flush.

Optional Feature:
- Macro ALU_HAZARD_PERF_EN.
- Defined:
  - Adds outputs stallCount and flushCount, each PERF_CNT_W.
  - Each increments on cycles where stall / flush is 1.
  - Both saturate at all-ones; both clear on rst.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Shared define header holds:
  - ALUMuxSelectBus and select encodings (FromReg/FromALU_MEM/FromMEM_WB).
  - Register-address bus width.
  - Stage-record field widths.
- One sub-module: fwd_select_unit. Combinational; instantiated twice, once per operand, taking {ex.rsX, useFlag, mem record, wb record} and returning the select.

Test Plan:
- Reset: rst = 1 for 2 cycles with decValid = 1 -> select1 = select2 = 00, stall = 0, bubble = 0; all records invalid after release.
- ALU-ALU forward: add x5 then sub x6,x5,x7 back-to-back -> while sub in ex, select1 = 01, select2 = 00; one cycle later a third instr reading x5 gets select = 10.
- Priority: writes to x3 in consecutive instrs, then reader of x3 -> select1 = 01 (newest), not 10.
- x0 guard: addi x0 then reader of x0 -> select1 = 00.
- Load-use: lw x8 then add x9,x8,x1 -> stall = 1, bubble = 1 for exactly 1 cycle; add later in ex with select1 = 10; decUsesRs2 = 0 with rs2 = x8 -> no stall.
- Flush during loadUse -> stall = 0, bubble = 1, ex invalid next cycle.
- Under ALU_HAZARD_PERF_EN, after 3 stalls -> stallCount = 3.
